banked_register_file: RTL

- Parametrised successor to the NanoRisc register bank: NUM_BANKS banks of 2^ADDR_W registers, each DATA_W bits wide.
- Provides three combinational read ports with write-bypass and a generalised cross-bank send.
- Bank 0 carries a dedicated $mem port and a dedicated $ra port.
- A sequential save/restore engine copies one selected bank to and from a shadow bank, one register per cycle, under a busy/done handshake.

---
 rtl/banked_register_file.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/banked_register_file.sv
// Banked register file: NUM_BANKS banks of 2^ADDR_W regs, three bypassed
// read ports, cross-bank send, bank0 $mem/$ra ports, and a save/restore
// engine that copies one bank to/from a shadow bank one register per cycle.
// Ports:
//   clock, reset_n                  clock and async active-low reset
//   readRegN/readBankN -> dataN     combinational reads with write bypass
//   writeReg/writeBank/writeData    register write (RegWrite)
//   isSend                          write source is data1
//   memWrite/RegMemWrite            bank0[MEM_REG] write
//   memRead/raRead                  bank0 $mem / $ra views
//   saveReq/restoreReq/ctxBank      save/restore requests
//   busy/done                       engine status
module banked_register_file #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 2,
   parameter int NUM_BANKS = 2,
   parameter int MEM_REG   = 1,
   parameter int RA_REG    = 0,
   localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] readReg1,
   input  logic [ADDR_W-1:0] readReg2,
   input  logic [ADDR_W-1:0] readReg3,
   input  logic [BANK_W-1:0] readBank1,
   input  logic [BANK_W-1:0] readBank2,
   input  logic [BANK_W-1:0] readBank3,
   input  logic [ADDR_W-1:0] writeReg,
   input  logic [BANK_W-1:0] writeBank,
   input  logic [DATA_W-1:0] writeData,
   input  logic              RegWrite,
   input  logic              isSend,
   input  logic [DATA_W-1:0] memWrite,
   input  logic              RegMemWrite,
   input  logic              saveReq,
   input  logic              restoreReq,
   input  logic [BANK_W-1:0] ctxBank,
   output logic [DATA_W-1:0] data1,
   output logic [DATA_W-1:0] data2,
   output logic [DATA_W-1:0] data3,
   output logic [DATA_W-1:0] memRead,
   output logic [DATA_W-1:0] raRead,
   output logic              busy,
   output logic              done
);

   localparam int NREGS = 2 ** ADDR_W;
   localparam logic [BANK_W:0] NB = NUM_BANKS[BANK_W:0];
   localparam logic [ADDR_W-1:0] MEM_IDX = MEM_REG[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] RA_IDX = RA_REG[ADDR_W-1:0];
   localparam logic [ADDR_W-1:0] LAST = '1;

   typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

   logic [DATA_W-1:0] regs [NUM_BANKS][NREGS];
   logic [DATA_W-1:0] shadow [NREGS];

   state_t            state;
   logic [BANK_W-1:0] ctx;
   logic [ADDR_W-1:0] idx;

   logic              mem_we;
   logic              reg_we;
   logic              mem_hit_w;
   logic [DATA_W-1:0] wval;
   logic [DATA_W-1:0] raw1;
   logic [DATA_W-1:0] raw2;
   logic [DATA_W-1:0] raw3;

   function automatic logic bank_ok(input logic [BANK_W-1:0] b);
      return {1'b0, b} < NB;
   endfunction

   function automatic logic [DATA_W-1:0] rd_raw(
      input logic [BANK_W-1:0] b,
      input logic [ADDR_W-1:0] r
   );
      return bank_ok(b) ? regs[b][r] : '0;
   endfunction

   // mem write has priority; when both target bank0[MEM_REG] the
   // register write is suppressed rather than overwritten
   function automatic logic [DATA_W-1:0] bypass(
      input logic [BANK_W-1:0] b,
      input logic [ADDR_W-1:0] r,
      input logic [DATA_W-1:0] raw
   );
      if (mem_we && b == '0 && r == MEM_IDX)
         return memWrite;
      if (reg_we && b == writeBank && r == writeReg)
         return wval;
      return raw;
   endfunction

   always_comb begin
      raw1 = rd_raw(readBank1, readReg1);
      raw2 = rd_raw(readBank2, readReg2);
      raw3 = rd_raw(readBank3, readReg3);
      mem_we = RegMemWrite && !busy;
      mem_hit_w = mem_we && writeBank == '0 && writeReg == MEM_IDX;
      reg_we = RegWrite && !busy && bank_ok(writeBank) && !mem_hit_w;
      // a send takes the stored value, never its own bypass
      wval = isSend ? raw1 : writeData;
      data1 = isSend ? raw1 : bypass(readBank1, readReg1, raw1);
      data2 = bypass(readBank2, readReg2, raw2);
      data3 = bypass(readBank3, readReg3, raw3);
      memRead = regs[0][MEM_IDX];
      raRead = regs[0][RA_IDX];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int b = 0; b < NUM_BANKS; b++)
            for (int r = 0; r < NREGS; r++)
               regs[b][r] <= '0;
         for (int r = 0; r < NREGS; r++)
            shadow[r] <= '0;
         state <= IDLE;
         ctx   <= '0;
         idx   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (reg_we)
            regs[writeBank][writeReg] <= wval;
         if (mem_we)
            regs[0][MEM_IDX] <= memWrite;
         unique case (state)
            IDLE: begin
               done <= 1'b0;
               if (saveReq || restoreReq) begin
                  ctx   <= ctxBank;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= saveReq ? SAVE : RESTORE;
               end
            end
            SAVE, RESTORE: begin
               if (state == SAVE)
                  shadow[idx] <= rd_raw(ctx, idx);
               else if (bank_ok(ctx))
                  regs[ctx][idx] <= shadow[idx];
               if (idx == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
